// File: rtl/vga_capture_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vga_capture_monitor
// Purpose  : Receive-side VGA monitor. Samples the VGA bus in the CLOCK_50
//            domain, locks to HS/VS, measures line and frame length, counts
//            active pixels/lines, keeps a per-frame rotate-XOR checksum and
//            raises sticky timing error flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : CLOCK_50      in   system clock, only clock
//            reset_n       in   asynchronous active-low reset
//            VGA_CLK       in   pixel clock, sampled as data (rise = strobe)
//            VGA_HS/VS     in   syncs, active low
//            VGA_BLANK_N   in   1 = active pixel
//            VGA_R/G/B     in   pixel colour, 8 bits each
//            clr_err       in   pulse, clears err_flags (new errors win)
//            locked        out  frame timing matches parameters
//            frame_done    out  1-cycle pulse per frame boundary while locked
//            frame_sum     out  checksum of previous complete frame
//            h_meas        out  last line length in pixel strobes
//            v_meas        out  last frame length in lines
//            err_flags     out  sticky [0] line len [1] act px/line
//                                      [2] frame len [3] active lines
//            frame_count   out  clean frames since reset
// Options  : VGA_CAP_STATS_EN - enables the frame_count counter; otherwise
//            frame_count is tied to zero.
// ============================================================================
module vga_capture_monitor #(
    parameter int H_TOTAL  = 800,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_ACTIVE = 480,
    parameter int CNT_W    = 12
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             VGA_CLK,
    input  logic             VGA_HS,
    input  logic             VGA_VS,
    input  logic             VGA_BLANK_N,
    input  logic [7:0]       VGA_R,
    input  logic [7:0]       VGA_G,
    input  logic [7:0]       VGA_B,
    input  logic             clr_err,
    output logic             locked,
    output logic             frame_done,
    output logic [23:0]      frame_sum,
    output logic [CNT_W-1:0] h_meas,
    output logic [CNT_W-1:0] v_meas,
    output logic [3:0]       err_flags,
    output logic [15:0]      frame_count
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_h_total  = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] c_h_active = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_v_total  = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] c_v_active = CNT_W'(V_ACTIVE);

    // Input sampling stage
    logic             in_clk_q, in_clk_dly_q, in_hs_q, in_vs_q, in_blank_q;
    logic [23:0]      in_rgb_q;

    logic             hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, act_px_q, act_px_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d, act_lines_q, act_lines_d;
    logic             line_ok_q, line_ok_d;
    logic [23:0]      sum_q, sum_d;
    logic             locked_q, locked_d, frame_done_q, frame_done_d;
    logic [23:0]      frame_sum_q, frame_sum_d;
    logic [CNT_W-1:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
    logic [3:0]       err_q, err_d;

    logic             pix_stb, hs_fall, vs_fall, run, h_ok, act_full;
    logic [CNT_W-1:0] v_line, lines_line;
    logic             line_ok_line;
    logic [3:0]       new_err;

    // Strobe fires once per VGA_CLK rise; data regs were captured on the
    // same edge as in_clk_q, so they are consistent with the strobe.
    assign pix_stb  = in_clk_q & ~in_clk_dly_q;
    assign hs_fall  = pix_stb & hs_prev_q & ~in_hs_q;
    assign vs_fall  = pix_stb & vs_prev_q & ~in_vs_q;
    assign run      = (state_q != SEARCH);
    assign h_ok     = (h_cnt_q == c_h_total);
    assign act_full = (act_px_q == c_h_active);

    always_comb begin
        hs_prev_d    = pix_stb ? in_hs_q : hs_prev_q;
        vs_prev_d    = pix_stb ? in_vs_q : vs_prev_q;
        state_d      = state_q;
        h_cnt_d      = h_cnt_q;
        act_px_d     = act_px_q;
        sum_d        = sum_q;
        frame_sum_d  = frame_sum_q;
        frame_done_d = 1'b0;
        h_meas_d     = h_meas_q;
        v_meas_d     = v_meas_q;
        new_err      = 4'd0;
        v_line       = v_cnt_q;
        lines_line   = act_lines_q;
        line_ok_line = line_ok_q;

        // Line measurement runs in every state so h_meas stays meaningful
        // while searching; the sync strobe is the first pixel of a line.
        if (hs_fall) begin
            h_meas_d = h_cnt_q;
            h_cnt_d  = c_one;
            act_px_d = in_blank_q ? c_one : '0;
        end else if (pix_stb) begin
            if (h_cnt_q != c_cnt_max)
                h_cnt_d = h_cnt_q + c_one;
            if (in_blank_q && (act_px_q != c_cnt_max))
                act_px_d = act_px_q + c_one;
        end

        // Line close: the values after it feed the frame close below so a
        // coincident HS+VS strobe counts this line toward the closing frame.
        if (hs_fall && run) begin
            if (v_cnt_q != c_cnt_max)
                v_line = v_cnt_q + c_one;
            if (act_full && (act_lines_q != c_cnt_max))
                lines_line = act_lines_q + c_one;
            line_ok_line = line_ok_q & h_ok;
            if (state_q == LOCKED) begin
                new_err[0] = ~h_ok;
                new_err[1] = (act_px_q != '0) & ~act_full;
            end
        end

        if (pix_stb && in_blank_q && run)
            sum_d = {sum_q[22:0], sum_q[23]} ^ in_rgb_q;

        v_cnt_d     = v_line;
        act_lines_d = lines_line;
        line_ok_d   = line_ok_line;

        if (vs_fall) begin
            v_cnt_d     = '0;
            act_lines_d = '0;
            line_ok_d   = 1'b1;
            sum_d       = '0;
            case (state_q)
                SEARCH: state_d = ALIGN;
                ALIGN: begin
                    v_meas_d = v_line;
                    if ((v_line == c_v_total) && line_ok_line)
                        state_d = LOCKED;
                end
                LOCKED: begin
                    v_meas_d     = v_line;
                    new_err[2]   = (v_line != c_v_total);
                    new_err[3]   = (lines_line != c_v_active);
                    frame_sum_d  = sum_q;
                    frame_done_d = 1'b1;
                end
                default: state_d = SEARCH;
            endcase
        end

        // Structural timing errors drop lock; content errors only flag.
        if ((state_q == LOCKED) && (new_err[0] || new_err[2]))
            state_d = SEARCH;

        err_d    = (clr_err ? 4'd0 : err_q) | new_err;
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            in_clk_q     <= 1'b0;
            in_clk_dly_q <= 1'b0;
            in_hs_q      <= 1'b1;
            in_vs_q      <= 1'b1;
            in_blank_q   <= 1'b0;
            in_rgb_q     <= '0;
            hs_prev_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            state_q      <= SEARCH;
            h_cnt_q      <= '0;
            act_px_q     <= '0;
            v_cnt_q      <= '0;
            act_lines_q  <= '0;
            line_ok_q    <= 1'b1;
            sum_q        <= '0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_sum_q  <= '0;
            h_meas_q     <= '0;
            v_meas_q     <= '0;
            err_q        <= '0;
        end else begin
            in_clk_q     <= VGA_CLK;
            in_clk_dly_q <= in_clk_q;
            in_hs_q      <= VGA_HS;
            in_vs_q      <= VGA_VS;
            in_blank_q   <= VGA_BLANK_N;
            in_rgb_q     <= {VGA_R, VGA_G, VGA_B};
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            act_px_q     <= act_px_d;
            v_cnt_q      <= v_cnt_d;
            act_lines_q  <= act_lines_d;
            line_ok_q    <= line_ok_d;
            sum_q        <= sum_d;
            locked_q     <= locked_d;
            frame_done_q <= frame_done_d;
            frame_sum_q  <= frame_sum_d;
            h_meas_q     <= h_meas_d;
            v_meas_q     <= v_meas_d;
            err_q        <= err_d;
        end
    end

`ifdef VGA_CAP_STATS_EN
    logic        frame_err_q, frame_err_d;
    logic [15:0] frame_count_q, frame_count_d;

    // A frame is clean only if no error event occurred anywhere in it,
    // including the checks made on its closing strobe.
    always_comb begin
        frame_err_d   = vs_fall ? 1'b0 : (frame_err_q | (|new_err));
        frame_count_d = frame_count_q;
        if (frame_done_d && !(frame_err_q || (|new_err)) && (frame_count_q != 16'hFFFF))
            frame_count_d = frame_count_q + 16'd1;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = 16'd0;
`endif

    assign locked     = locked_q;
    assign frame_done = frame_done_q;
    assign frame_sum  = frame_sum_q;
    assign h_meas     = h_meas_q;
    assign v_meas     = v_meas_q;
    assign err_flags  = err_q;

endmodule
`default_nettype wire
